// File: rtl/packet_injector.sv
// Network-interface transmitter: latches one packet over valid/ready and
// serialises it, LSB flit first, into a router input FIFO with full-flag flow control.
module packet_injector #(
    parameter int PACKET_SIZE  = 32,
    parameter int ADDRESS_SIZE = 16,
    parameter int FLIT_SIZE    = 4,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                pkt_valid,
    input  logic [ADDRESS_SIZE-1:0]             pkt_addr,
    input  logic [PACKET_SIZE-ADDRESS_SIZE-1:0] pkt_data,
    output logic                                pkt_ready,
    input  logic                                fifo_full,
    output logic                                write_fifo,
    output logic [FLIT_SIZE-1:0]                flit_out,
    output logic                                busy,
    output logic                                pkt_sent,
    output logic [COUNT_WIDTH-1:0]              pkt_count
);

    localparam int FLITS = PACKET_SIZE / FLIT_SIZE;
    localparam int IDX_W = (FLITS > 1) ? $clog2(FLITS) : 1;

    if ((PACKET_SIZE % FLIT_SIZE) != 0 || (ADDRESS_SIZE % FLIT_SIZE) != 0) begin : g_size_check
        $error("packet_injector: PACKET_SIZE and ADDRESS_SIZE must be multiples of FLIT_SIZE");
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state, state_nxt;
    logic [PACKET_SIZE-1:0] sr, sr_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic                   last_write;

    assign flit_out = sr[FLIT_SIZE-1:0];

    always_comb begin
        state_nxt  = state;
        sr_nxt     = sr;
        idx_nxt    = idx;
        pkt_ready  = 1'b0;
        busy       = 1'b0;
        write_fifo = 1'b0;
        last_write = 1'b0;
        case (state)
            IDLE: begin
                pkt_ready = 1'b1;
                if (pkt_valid) begin
                    sr_nxt    = {pkt_data, pkt_addr};
                    idx_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                busy       = 1'b1;
                write_fifo = ~fifo_full;
                // A stalled flit stays at the bottom of SR and is retried next cycle.
                if (!fifo_full) begin
                    sr_nxt  = {{FLIT_SIZE{1'b0}}, sr[PACKET_SIZE-1:FLIT_SIZE]};
                    idx_nxt = idx + IDX_W'(1);
                    if (idx == IDX_W'(FLITS - 1)) begin
                        last_write = 1'b1;
                        state_nxt  = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sr        <= '0;
            idx       <= '0;
            pkt_sent  <= 1'b0;
            pkt_count <= '0;
        end else begin
            state    <= state_nxt;
            sr       <= sr_nxt;
            idx      <= idx_nxt;
            pkt_sent <= last_write;
            if (last_write)
                pkt_count <= pkt_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_packet_injector.sv
// Randomised self-checking bench for packet_injector; a second instance with a
// 3-bit counter exercises counter wrap within a short run.
module tb_packet_injector;

    logic        clk = 1'b0;
    logic        reset;
    logic        pkt_valid;
    logic [15:0] pkt_addr;
    logic [15:0] pkt_data;
    logic        fifo_full;

    logic        pkt_ready, write_fifo, busy, pkt_sent;
    logic [3:0]  flit_out;
    logic [15:0] pkt_count;
    logic        w_pkt_ready, w_write_fifo, w_busy, w_pkt_sent;
    logic [3:0]  w_flit_out;
    logic [2:0]  w_pkt_count;

    logic [7:0]  st, w_st;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_count = 0;

    assign st   = {pkt_ready, write_fifo, busy, pkt_sent, flit_out};
    assign w_st = {w_pkt_ready, w_write_fifo, w_busy, w_pkt_sent, w_flit_out};

    always #5 clk = ~clk;

    packet_injector dut (
        .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .pkt_addr(pkt_addr),
        .pkt_data(pkt_data), .pkt_ready(pkt_ready), .fifo_full(fifo_full),
        .write_fifo(write_fifo), .flit_out(flit_out), .busy(busy),
        .pkt_sent(pkt_sent), .pkt_count(pkt_count)
    );

    packet_injector #(.COUNT_WIDTH(3)) dut_w (
        .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .pkt_addr(pkt_addr),
        .pkt_data(pkt_data), .pkt_ready(w_pkt_ready), .fifo_full(fifo_full),
        .write_fifo(w_write_fifo), .flit_out(w_flit_out), .busy(w_busy),
        .pkt_sent(w_pkt_sent), .pkt_count(w_pkt_count)
    );

    // Expected status word {pkt_ready, write_fifo, busy, pkt_sent, flit_out}.
    function automatic logic [7:0] status(input bit rdy, input bit wr, input bit bsy,
                                          input bit snt, input logic [3:0] f);
        return {rdy, wr, bsy, snt, f};
    endfunction

    // Called at posedge+1. With pre=1 the packet was already accepted at the previous edge.
    // With hold=1 pkt_valid stays high carrying (na,nd) so the next packet is chained.
    task automatic send_pkt(input string nm, input logic [15:0] a, input logic [15:0] d,
                            input logic [31:0] stall, input bit hold, input logic [15:0] na,
                            input logic [15:0] nd, input bit pre, input int abort_at);
        logic [31:0] pkt;
        logic [7:0]  e;
        int          k;
        int          c;
        pkt = {d, a};
        k = 0;
        c = 0;
        if (!pre) begin
            pkt_valid = 1'b1; pkt_addr = a; pkt_data = d; fifo_full = 1'b0;
            @(negedge clk);
            e = status(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
            n_cmp++;
            if ({st, w_st} !== {e, e}) begin
                n_bad++;
                $display("FAIL %s idle: got %h/%h expected %h", nm, st, w_st, e);
            end
            @(posedge clk); #1;
        end
        pkt_valid = hold;
        pkt_addr  = hold ? na : 16'($urandom);
        pkt_data  = hold ? nd : 16'($urandom);
        while (k < 8 && c < 40) begin
            fifo_full = (c < 32) ? stall[c] : 1'b0;
            if (abort_at > 0 && k == abort_at) begin
                fifo_full = 1'b0;
                reset = 1'b1;
                exp_count = 0;
                #1;
                e = status(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
                n_cmp++;
                if ({st, w_st, pkt_count, w_pkt_count} !== {e, e, 16'd0, 3'd0}) begin
                    n_bad++;
                    $display("FAIL %s abort: got %h/%h cnt %0d expected %h cnt 0",
                             nm, st, w_st, pkt_count, e);
                end
                pkt_valid = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                @(posedge clk); #1;
                return;
            end
            @(negedge clk);
            e = status(1'b0, ~fifo_full, 1'b1, 1'b0, 4'((pkt >> (4 * k)) & 32'hF));
            n_cmp++;
            if ({st, w_st} !== {e, e}) begin
                n_bad++;
                $display("FAIL %s send cyc %0d flit %0d: got %h/%h expected %h",
                         nm, c, k, st, w_st, e);
            end
            if (!fifo_full) k++;
            @(posedge clk); #1;
            c++;
        end
        fifo_full = 1'b0;
        if (k < 8) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: flits %0d expected 8", nm, k);
        end
        exp_count++;
        @(negedge clk);
        e = status(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
        n_cmp++;
        if ({st, w_st, pkt_count, w_pkt_count} !== {e, e, 16'(exp_count), 3'(exp_count)}) begin
            n_bad++;
            $display("FAIL %s done: got %h/%h cnt %0d/%0d expected %h cnt %0d/%0d",
                     nm, st, w_st, pkt_count, w_pkt_count, e,
                     exp_count % 65536, exp_count % 8);
        end
        @(posedge clk); #1;
        if (!hold) pkt_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        reset = 1'b1; pkt_valid = 1'b0; pkt_addr = '0; pkt_data = '0; fifo_full = 1'b0;
        exp_count = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        e = status(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        n_cmp++;
        if ({st, w_st, pkt_count, w_pkt_count} !== {e, e, 16'd0, 3'd0}) begin
            n_bad++;
            $display("FAIL reset: got %h/%h cnt %0d expected %h cnt 0", st, w_st, pkt_count, e);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        send_pkt("basic", 16'hA3C5, 16'h1B2F, 32'h0, 1'b0, 16'h0, 16'h0, 1'b0, 0);
    endtask

    task automatic test_stall();
        send_pkt("stall", 16'hA3C5, 16'h1B2F, 32'h1C, 1'b0, 16'h0, 16'h0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] a2, d2;
        a2 = 16'($urandom); d2 = 16'($urandom);
        send_pkt("b2b_1", 16'($urandom), 16'($urandom), 32'h0, 1'b1, a2, d2, 1'b0, 0);
        send_pkt("b2b_2", a2, d2, 32'h0, 1'b0, 16'h0, 16'h0, 1'b1, 0);
    endtask

    task automatic test_reset_mid();
        send_pkt("abort", 16'hA3C5, 16'h1B2F, 32'h0, 1'b0, 16'h0, 16'h0, 1'b0, 3);
        send_pkt("after_abort", 16'h7E94, 16'hD06B, 32'h0, 1'b0, 16'h0, 16'h0, 1'b0, 0);
    endtask

    task automatic test_last_stall();
        send_pkt("last_stall", 16'hA3C5, 16'h1B2F, 32'h180, 1'b0, 16'h0, 16'h0, 1'b0, 0);
    endtask

    task automatic test_random();
        logic [15:0] a, d, na, nd;
        bit          pre;
        bit          hold;
        pre = 1'b0;
        a = 16'($urandom); d = 16'($urandom);
        for (int i = 0; i < 12; i++) begin
            na = 16'($urandom); nd = 16'($urandom);
            hold = (i < 11) && ($urandom_range(0, 1) == 1);
            send_pkt("random", a, d, $urandom & $urandom & 32'h0000FFFF, hold, na, nd, pre, 0);
            pre = hold;
            a = na; d = nd;
        end
    endtask

    task automatic test_wrap();
        test_reset();
        for (int i = 0; i < 9; i++)
            send_pkt("wrap", 16'($urandom), 16'($urandom), 32'h0, 1'b0, 16'h0, 16'h0, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_last_stall();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
